vga_fb_arbiter: RTL and testbench

Shares one single-port framebuffer SRAM between the VGA scan-out fetch and two pixel writers (draw engine, host loader), one access per clk. Display fetch has absolute priority because it has a hard line deadline. Writers are served round-robin in the remaining slots. Sits between the VGA timing/pixel path and the SRAM controller in mojo_top, with a sticky starvation flag for bring-up and debug.

---
 rtl/vga_fb_arbiter.sv | 151 +++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer SRAM arbiter: display fetch has absolute priority, and the two
// pixel writers share the remaining slots round-robin. It also raises a sticky starvation flag.
module vga_fb_arbiter #(
    parameter int AW         = 15,
    parameter int DW         = 16,
    parameter int READ_LAT   = 2,
    parameter int STARVE_LIM = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_ack,
    output logic          disp_rvalid,
    output logic [DW-1:0] disp_rdata,
    input  logic          wr0_req,
    input  logic [AW-1:0] wr0_addr,
    input  logic [DW-1:0] wr0_data,
    output logic          wr0_ack,
    input  logic          wr1_req,
    input  logic [AW-1:0] wr1_addr,
    input  logic [DW-1:0] wr1_data,
    output logic          wr1_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          wr_starved
);

    localparam int            CW    = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] LIM_C = CW'(STARVE_LIM);

    logic              w_disp_ack;
    logic              w_wr0_ack;
    logic              w_wr1_ack;
    logic [CW-1:0]     w_wait0_nxt;
    logic [CW-1:0]     w_wait1_nxt;
    logic              r_rr_ptr;
    logic [READ_LAT:0] r_rd_pipe;
    logic [CW-1:0]     r_wait0;
    logic [CW-1:0]     r_wait1;

    function automatic logic [CW-1:0] wait_next(input logic req, input logic ack,
                                                input logic [CW-1:0] cnt);
        logic [CW-1:0] nxt;
        if (!req || ack) begin
            nxt = {CW{1'b0}};
        end else if (cnt == LIM_C) begin
            nxt = cnt;
        end else begin
            nxt = cnt + CW'(1);
        end
        return nxt;
    endfunction

    // Grant decision: display first, then the lone writer, else rr_ptr picks.
    always_comb begin
        w_disp_ack = 1'b0;
        w_wr0_ack  = 1'b0;
        w_wr1_ack  = 1'b0;
        if (rst) begin
            w_disp_ack = 1'b0;
        end else if (disp_req) begin
            w_disp_ack = 1'b1;
        end else if (wr0_req && wr1_req) begin
            if (r_rr_ptr) begin
                w_wr1_ack = 1'b1;
            end else begin
                w_wr0_ack = 1'b1;
            end
        end else if (wr0_req) begin
            w_wr0_ack = 1'b1;
        end else if (wr1_req) begin
            w_wr1_ack = 1'b1;
        end else begin
            w_disp_ack = 1'b0;
        end
    end

    assign disp_ack    = w_disp_ack;
    assign wr0_ack     = w_wr0_ack;
    assign wr1_ack     = w_wr1_ack;
    assign w_wait0_nxt = wait_next(wr0_req, w_wr0_ack, r_wait0);
    assign w_wait1_nxt = wait_next(wr1_req, w_wr1_ack, r_wait1);

    // Issue the granted access to the SRAM one cycle after the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= {AW{1'b0}};
            mem_wdata <= {DW{1'b0}};
            r_rr_ptr  <= 1'b0;
        end else begin
            mem_en <= w_disp_ack | w_wr0_ack | w_wr1_ack;
            if (w_disp_ack) begin
                mem_we   <= 1'b0;
                mem_addr <= disp_addr;
            end else if (w_wr0_ack) begin
                mem_we    <= 1'b1;
                mem_addr  <= wr0_addr;
                mem_wdata <= wr0_data;
                r_rr_ptr  <= 1'b1;
            end else if (w_wr1_ack) begin
                mem_we    <= 1'b1;
                mem_addr  <= wr1_addr;
                mem_wdata <= wr1_data;
                r_rr_ptr  <= 1'b0;
            end else begin
                mem_we <= 1'b0;
            end
        end
    end

    // Track display reads so data is returned READ_LAT+2 cycles after the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_pipe   <= {(READ_LAT + 1){1'b0}};
            disp_rvalid <= 1'b0;
            disp_rdata  <= {DW{1'b0}};
        end else begin
            r_rd_pipe   <= {r_rd_pipe[READ_LAT-1:0], w_disp_ack};
            disp_rvalid <= r_rd_pipe[READ_LAT];
            if (r_rd_pipe[READ_LAT]) begin
                disp_rdata <= mem_rdata;
            end else begin
                disp_rdata <= disp_rdata;
            end
        end
    end

    // Per-writer wait counters; the flag stays set until reset once any counter saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait0    <= {CW{1'b0}};
            r_wait1    <= {CW{1'b0}};
            wr_starved <= 1'b0;
        end else begin
            r_wait0 <= w_wait0_nxt;
            r_wait1 <= w_wait1_nxt;
            if ((w_wait0_nxt == LIM_C) || (w_wait1_nxt == LIM_C)) begin
                wr_starved <= 1'b1;
            end else begin
                wr_starved <= wr_starved;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Scoreboard bench for vga_fb_arbiter. Stimulus pushes expected SRAM accesses and
// read returns, which a forked monitor pops and compares when the DUT presents them.
module tb_vga_fb_arbiter;

    localparam int RL = 2;

    typedef struct {
        int          cyc;
        logic        we;
        logic [14:0] addr;
        logic [15:0] wdata;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic [15:0] data;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        disp_req, wr0_req, wr1_req;
    logic [14:0] disp_addr, wr0_addr, wr1_addr;
    logic [15:0] wr0_data, wr1_data;
    logic        disp_ack, wr0_ack, wr1_ack, disp_rvalid;
    logic [15:0] disp_rdata;
    logic        mem_en, mem_we, wr_starved;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc_n    = 0;
    logic        exp_starved;
    logic        mem_load;
    logic [15:0] sram    [0:2047];
    logic [15:0] ref_mem [0:2047];
    logic [15:0] rd_s1, rd_s2;
    mem_exp_t    exp_mem[$];
    rd_exp_t     exp_rd[$];
    int          i0, i1;

    vga_fb_arbiter #(.AW(15), .DW(16), .READ_LAT(RL), .STARVE_LIM(8)) dut (
        .clk(clk), .rst(rst),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ack(wr0_ack),
        .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ack(wr1_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .wr_starved(wr_starved)
    );

    always #5 clk = ~clk;

    // Cycle index: during cycle k (after the k-th rising edge) cyc_n == k.
    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic logic [15:0] init_val(input logic [14:0] a);
        return 16'h7FFF ^ {1'b0, a} ^ 16'h0123;
    endfunction

    // SRAM model with a two-cycle read latency from mem_en.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 2048; i++) sram[i] <= init_val(15'(i));
        end else if (mem_en === 1'b1 && mem_we === 1'b1) begin
            sram[mem_addr[10:0]] <= mem_wdata;
        end
        rd_s1 <= sram[mem_addr[10:0]];
        rd_s2 <= rd_s1;
    end
    assign mem_rdata = rd_s2;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endfunction

    task automatic unexpected(input string name);
        n_assert++;
        n_fail++;
        $display("FAIL %s: output present with nothing expected (cycle %0d)", name, cyc_n);
    endtask

    task automatic monitor();
        mem_exp_t me;
        rd_exp_t  re;
        forever begin
            @(negedge clk);
            if (mem_en === 1'b1) begin
                if (exp_mem.size() == 0) begin
                    unexpected("mem_access");
                end else begin
                    me = exp_mem.pop_front();
                    check("mem_cycle", cyc_n, me.cyc);
                    check("mem_we", {31'd0, mem_we}, {31'd0, me.we});
                    check("mem_addr", {17'd0, mem_addr}, {17'd0, me.addr});
                    if (me.we) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, me.wdata});
                end
            end
            if (disp_rvalid === 1'b1) begin
                if (exp_rd.size() == 0) begin
                    unexpected("disp_rvalid");
                end else begin
                    re = exp_rd.pop_front();
                    check("rvalid_cycle", cyc_n, re.cyc);
                    check("disp_rdata", {16'd0, disp_rdata}, {16'd0, re.data});
                end
            end
        end
    endtask

    // One bus cycle: drive inputs, check grants and flag, log expected accesses.
    task automatic cyc(input logic r, input logic dq, input logic [14:0] da,
                       input logic q0, input logic [14:0] a0, input logic [15:0] d0,
                       input logic q1, input logic [14:0] a1, input logic [15:0] d1,
                       input logic [2:0] ea, input logic prd);
        mem_exp_t me;
        rd_exp_t  re;
        rst = r; disp_req = dq; disp_addr = da;
        wr0_req = q0; wr0_addr = a0; wr0_data = d0;
        wr1_req = q1; wr1_addr = a1; wr1_data = d1;
        #2;
        check("acks{disp,wr1,wr0}", {29'd0, disp_ack, wr1_ack, wr0_ack}, {29'd0, ea});
        check("wr_starved", {31'd0, wr_starved}, {31'd0, exp_starved});
        me.cyc = cyc_n + 1;
        if (ea[2]) begin
            me.we = 1'b0; me.addr = da; me.wdata = '0;
            exp_mem.push_back(me);
            if (prd) begin
                re.cyc  = cyc_n + RL + 2;
                re.data = ref_mem[da[10:0]];
                exp_rd.push_back(re);
            end
        end else if (ea[0]) begin
            me.we = 1'b1; me.addr = a0; me.wdata = d0;
            exp_mem.push_back(me);
            ref_mem[a0[10:0]] = d0;
        end else if (ea[1]) begin
            me.we = 1'b1; me.addr = a1; me.wdata = d1;
            exp_mem.push_back(me);
            ref_mem[a1[10:0]] = d1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0, 3'b000, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) ref_mem[i] = init_val(15'(i));
        exp_starved = 1'b0;
        mem_load = 1'b1;
        rst = 1'b1; disp_req = 1'b1; wr0_req = 1'b1; wr1_req = 1'b1;
        disp_addr = '0; wr0_addr = '0; wr1_addr = '0; wr0_data = '0; wr1_data = '0;
        i0 = 0; i1 = 0;
        @(posedge clk);
        #1;
        mem_load = 1'b0;

        // Reset held two cycles with every requester active: no grants.
        for (int k = 0; k < 2; k++)
            cyc(1'b1, 1'b1, 15'h0001, 1'b1, 15'h0002, 16'h1111, 1'b1, 15'h0003, 16'h2222, 3'b000, 1'b0);
        fork
            monitor();
        join_none
        check("mem_en_after_rst", {31'd0, mem_en}, 32'd0);
        check("rvalid_after_rst", {31'd0, disp_rvalid}, 32'd0);
        idle(1);

        // Single display read of 0x0123; the model returns 0x7FFF four cycles later.
        cyc(1'b0, 1'b1, 15'h0123, 1'b0, '0, '0, 1'b0, '0, '0, 3'b100, 1'b1);
        idle(5);

        // Both writers continuously: alternate wr0, wr1 with no idle SRAM slot.
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                cyc(1'b0, 1'b0, '0, 1'b1, 15'(16 + i0), 16'(16'hA000 + i0),
                    1'b1, 15'(32 + i1), 16'(16'hB000 + i1), 3'b001, 1'b0);
                i0++;
            end else begin
                cyc(1'b0, 1'b0, '0, 1'b1, 15'(16 + i0), 16'(16'hA000 + i0),
                    1'b1, 15'(32 + i1), 16'(16'hB000 + i1), 3'b010, 1'b0);
                i1++;
            end
        end

        // All three request for 4 cycles, then display drops: wr0 then wr1.
        for (int k = 0; k < 4; k++)
            cyc(1'b0, 1'b1, 15'(16'h0200 + k), 1'b1, 15'(16 + i0), 16'(16'hA000 + i0),
                1'b1, 15'(32 + i1), 16'(16'hB000 + i1), 3'b100, 1'b1);
        cyc(1'b0, 1'b0, '0, 1'b1, 15'(16 + i0), 16'(16'hA000 + i0),
            1'b1, 15'(32 + i1), 16'(16'hB000 + i1), 3'b001, 1'b0);
        i0++;
        cyc(1'b0, 1'b0, '0, 1'b0, '0, '0,
            1'b1, 15'(32 + i1), 16'(16'hB000 + i1), 3'b010, 1'b0);
        i1++;
        idle(5);

        // Read back a written word: returns wr1's second data word.
        cyc(1'b0, 1'b1, 15'h0021, 1'b0, '0, '0, 1'b0, '0, '0, 3'b100, 1'b1);
        idle(4);

        // Display hogs the bus while wr1 waits; flag rises after 8 waiting cycles.
        for (int k = 0; k < 10; k++) begin
            exp_starved = (k >= 8);
            cyc(1'b0, 1'b1, 15'(16'h0300 + k), 1'b0, '0, '0,
                1'b1, 15'h0777, 16'h1234, 3'b100, 1'b1);
        end
        cyc(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 15'h0777, 16'h1234, 3'b010, 1'b0);
        idle(5);
        cyc(1'b0, 1'b1, 15'h0777, 1'b0, '0, '0, 1'b0, '0, '0, 3'b100, 1'b1);
        idle(4);

        // Two back-to-back reads, then reset: their returns must never appear.
        cyc(1'b0, 1'b1, 15'h0400, 1'b0, '0, '0, 1'b0, '0, '0, 3'b100, 1'b0);
        cyc(1'b0, 1'b1, 15'h0401, 1'b0, '0, '0, 1'b0, '0, '0, 3'b100, 1'b0);
        cyc(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0, 3'b000, 1'b0);
        exp_starved = 1'b0;
        idle(6);
        cyc(1'b0, 1'b1, 15'h0402, 1'b0, '0, '0, 1'b0, '0, '0, 3'b100, 1'b1);
        idle(8);

        check("mem_queue_drained", exp_mem.size(), 32'd0);
        check("rd_queue_drained", exp_rd.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
